id_decode_queue: RTL and testbench
==================================

ID_DECODE_QUEUE -- requirements
Module: id_decode_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, raw-instruction queue entries, power of two, range 2..16.
REQ-002 SHALL have parameter RF_ADDR_W, default 5, register-id width; 5 = RV32I, 4 = RV32E.
REQ-003 SHALL have parameter EN_MEXT, default 0, 1 enables M-extension decode.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all queued and output-held instructions.
REQ-007 SHALL have port in_valid  input  1  fetch offers instruction.
REQ-008 SHALL have port in_ready  output  1  block accepts instruction this cycle.
REQ-009 SHALL have port in_instr  input  32  raw instruction word.
REQ-010 SHALL have port in_pc  input  32  instruction address.
REQ-011 SHALL have port out_valid  output  1  decoded bundle valid.
REQ-012 SHALL have port out_ready  input  1  execute consumes bundle.
REQ-013 SHALL have port out_dec  output  decode_t  registered bundle: pc, rd/rs1/rs2 ids (RF_ADDR_W), rs1_read, rs2_read, reg_write, alu_opcode[3:0], alu_op1_sel_zero/pc, alu_op2_sel_imm/4, imm[31:0], mem_read, mem_write, mem_opcode[2:0], branch, branch_opcode[2:0], jal, jalr, csr_read, csr_write, csr_op[1:0], csr_addr[11:0], mret, muldiv, muldiv_op[2:0], ill_instr.
REQ-014 SHALL have port count  output  $clog2(QUEUE_DEPTH)+1  queued entries, excluding output register.

Function
REQ-015 SHALL accept an instruction when in_valid & in_ready & ~flush; in_ready = (count < QUEUE_DEPTH).
REQ-016 SHALL load the output register when it is empty or out_ready is high in the same cycle (move condition).
REQ-017 On move with queue non-empty, SHALL load decode of queue head and pop it; same-cycle accept pushes in_instr to tail.
REQ-018 On move with queue empty and an accepted input, SHALL bypass: decode in_instr directly into output register (latency 1 cycle, accept cycle N -> out_valid at N+1).
REQ-019 SHALL hold out_dec and out_valid stable while out_valid & ~out_ready.
REQ-020 Simultaneous push and pop at count == QUEUE_DEPTH is impossible (in_ready low); push and pop at other counts SHALL leave count unchanged.
REQ-021 Read/write pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-022 flush SHALL, next edge, clear count, pointers and out_valid; input presented on a flush cycle is dropped; flush beats all other events.
REQ-023 Decode SHALL follow RV32I base: R, I, load, store, branch, LUI, AUIPC, JAL, JALR, CSR*, MRET semantics as in existing decoder; unknown opcode sets ill_instr.
REQ-024 Immediates: I = sext(i[31:20]); S = sext(i[31:25],i[11:7]); B = sext(i[31],i[7],i[30:25],i[11:8],0); U = i[31:12]<<12; J = sext(i[31],i[19:12],i[20],i[30:21],0); CSR-imm = zext(i[19:15]).
REQ-025 With RF_ADDR_W == 4, any used rd/rs1/rs2 field with bit 4 set SHALL set ill_instr and clear reg_write, mem_write, csr_write.
REQ-026 Opcode 0110011 with func7 == 0000001: EN_MEXT=1 -> muldiv=1, muldiv_op=func3, reg_write=1; EN_MEXT=0 -> ill_instr=1, reg_write=0.
REQ-027 ill_instr bundles SHALL still be delivered through the handshake (trap handled downstream).

Reset
REQ-028 While rst high: out_valid=0, count=0, pointers=0, in_ready=0 is not required -- in_ready SHALL be 1 after reset release; out_dec SHALL reset to all-zero.
REQ-029 Reset mid-transfer SHALL discard all entries with no partial bundle emitted.

Structure
REQ-030 decode_t struct, opcode/ALU/CSR/MEM constants SHALL live in shared package core_pkg.
REQ-031 Combinational decode SHALL be one sub-module id_decode_logic (instruction, pc -> decode_t), instanced once on the mux of queue head / in_instr.
REQ-032 Queue storage SHALL be a flop array; no vendor memory.

Verification
REQ-033 Bypass: empty, out_ready=1, in 0x002081B3 (ADD x3,x1,x2) cycle N -> cycle N+1 out_valid=1, rd=3, rs1=1, rs2=2, alu_opcode=0000, reg_write=1.
REQ-034 Back-pressure: out_ready=0, push 5 instructions with QUEUE_DEPTH=4 -> 1 in output reg, count=4, in_ready=0; release -> all 5 emerge in order.
REQ-035 Immediates: 0xFE000EE3 (BEQ x0,x0,-4) -> imm=0xFFFFFFFC, branch=1; 0x123452B7 (LUI x5) -> imm=0x12345000, rd=5.
REQ-036 M-ext: 0x022081B3 with EN_MEXT=1 -> muldiv=1, muldiv_op=000; EN_MEXT=0 -> ill_instr=1, reg_write=0.
REQ-037 RV32E: RF_ADDR_W=4, 0x01F00093 (ADDI x1,x0,31) legal; 0x00000F93 (ADDI x31,x0,0) -> ill_instr=1.
REQ-038 Flush with count=3 and out_valid=1 plus concurrent in_valid -> next cycle count=0, out_valid=0, input dropped.

Source files
------------

// File: rtl/core_pkg.sv
// Shared decode types and RV32 encoding constants for the front-end decode path.
package core_pkg;

   localparam int REG_ID_W = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // alu_opcode = {func7[5], func3}
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   localparam logic [1:0] CSR_RW = 2'b01;
   localparam logic [1:0] CSR_RS = 2'b10;
   localparam logic [1:0] CSR_RC = 2'b11;

   localparam logic [31:0] INSTR_MRET = 32'h3020_0073;

   typedef struct packed {
      logic [31:0]         pc;
      logic [REG_ID_W-1:0] rd;
      logic [REG_ID_W-1:0] rs1;
      logic [REG_ID_W-1:0] rs2;
      logic                rs1_read;
      logic                rs2_read;
      logic                reg_write;
      logic [3:0]          alu_opcode;
      logic                alu_op1_sel_zero;
      logic                alu_op1_sel_pc;
      logic                alu_op2_sel_imm;
      logic                alu_op2_sel_4;
      logic [31:0]         imm;
      logic                mem_read;
      logic                mem_write;
      logic [2:0]          mem_opcode;
      logic                branch;
      logic [2:0]          branch_opcode;
      logic                jal;
      logic                jalr;
      logic                csr_read;
      logic                csr_write;
      logic [1:0]          csr_op;
      logic [11:0]         csr_addr;
      logic                mret;
      logic                muldiv;
      logic [2:0]          muldiv_op;
      logic                ill_instr;
   } decode_t;

endpackage

// File: rtl/id_decode_logic.sv
// Purely combinational RV32I/E (+ optional M) decoder: instruction word and pc to decode_t.
module id_decode_logic
   import core_pkg::*;
#(
   parameter int RF_ADDR_W = 5,
   parameter int EN_MEXT   = 0
) (
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   output decode_t     dec
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        illegal;

   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      dec          = '0;
      illegal      = 1'b0;
      dec.pc       = pc;
      dec.rd       = instr[11:7];
      dec.rs1      = instr[19:15];
      dec.rs2      = instr[24:20];
      dec.csr_addr = instr[31:20];
      case (opc)
         OPC_OP: begin
            dec.rs1_read  = 1'b1;
            dec.rs2_read  = 1'b1;
            dec.reg_write = 1'b1;
            if (f7 == F7_MULDIV) begin
               dec.muldiv    = (EN_MEXT != 0);
               dec.muldiv_op = f3;
               illegal       = (EN_MEXT == 0);
            end else if (f7 == F7_BASE)
               dec.alu_opcode = {1'b0, f3};
            else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
               dec.alu_opcode = {1'b1, f3};
            else
               illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.rs1_read        = 1'b1;
            dec.reg_write       = 1'b1;
            dec.alu_op2_sel_imm = 1'b1;
            dec.imm             = imm_i;
            dec.alu_opcode      = {1'b0, f3};
            if (f3 == 3'b001 && f7 != F7_BASE)
               illegal = 1'b1;
            else if (f3 == 3'b101 && f7 == F7_ALT)
               dec.alu_opcode = {1'b1, f3};
            else if (f3 == 3'b101 && f7 != F7_BASE)
               illegal = 1'b1;
         end
         OPC_LOAD: begin
            dec.rs1_read        = 1'b1;
            dec.reg_write       = 1'b1;
            dec.mem_read        = 1'b1;
            dec.mem_opcode      = f3;
            dec.alu_op2_sel_imm = 1'b1;
            dec.imm             = imm_i;
            illegal             = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            dec.rs1_read        = 1'b1;
            dec.rs2_read        = 1'b1;
            dec.mem_write       = 1'b1;
            dec.mem_opcode      = f3;
            dec.alu_op2_sel_imm = 1'b1;
            dec.imm             = imm_s;
            illegal             = (f3 > 3'b010);
         end
         OPC_BRANCH: begin
            dec.rs1_read      = 1'b1;
            dec.rs2_read      = 1'b1;
            dec.branch        = 1'b1;
            dec.branch_opcode = f3;
            dec.alu_opcode    = ALU_SUB;
            dec.imm           = imm_b;
            illegal           = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LUI: begin
            dec.reg_write        = 1'b1;
            dec.alu_op1_sel_zero = 1'b1;
            dec.alu_op2_sel_imm  = 1'b1;
            dec.imm              = imm_u;
         end
         OPC_AUIPC: begin
            dec.reg_write       = 1'b1;
            dec.alu_op1_sel_pc  = 1'b1;
            dec.alu_op2_sel_imm = 1'b1;
            dec.imm             = imm_u;
         end
         OPC_JAL: begin
            dec.reg_write      = 1'b1;
            dec.jal            = 1'b1;
            dec.alu_op1_sel_pc = 1'b1;
            dec.alu_op2_sel_4  = 1'b1;
            dec.imm            = imm_j;
         end
         OPC_JALR: begin
            dec.rs1_read       = 1'b1;
            dec.reg_write      = 1'b1;
            dec.jalr           = 1'b1;
            dec.alu_op1_sel_pc = 1'b1;
            dec.alu_op2_sel_4  = 1'b1;
            dec.imm            = imm_i;
            illegal            = (f3 != 3'b000);
         end
         OPC_SYSTEM: begin
            if (f3 == 3'b000) begin
               dec.mret = (instr == INSTR_MRET);
               illegal  = (instr != INSTR_MRET);
            end else if (f3 == 3'b100)
               illegal = 1'b1;
            else begin
               dec.reg_write = 1'b1;
               dec.csr_read  = 1'b1;
               dec.csr_op    = f3[1:0];
               // set/clear with a zero source must not side-effect the CSR
               dec.csr_write = (f3[1:0] == CSR_RW) || (instr[19:15] != 5'd0);
               if (f3[2])
                  dec.imm = {27'd0, instr[19:15]};
               else
                  dec.rs1_read = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase

      // Register ids stay 5 bits wide; a reduced file flags any used id above x15.
      if (RF_ADDR_W == 4 && ((dec.reg_write && dec.rd[4]) || (dec.rs1_read && dec.rs1[4]) ||
                             (dec.rs2_read && dec.rs2[4])))
         illegal = 1'b1;

      if (illegal) begin
         dec.ill_instr = 1'b1;
         dec.reg_write = 1'b0;
         dec.mem_write = 1'b0;
         dec.csr_write = 1'b0;
      end
   end

endmodule

// File: rtl/id_decode_queue.sv
// Raw-instruction queue feeding a single registered decode stage, with empty-queue bypass.
module id_decode_queue
   import core_pkg::*;
#(
   parameter int QUEUE_DEPTH = 4,
   parameter int RF_ADDR_W   = 5,
   parameter int EN_MEXT     = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [31:0]                    in_instr,
   input  logic [31:0]                    in_pc,
   output logic                           out_valid,
   input  logic                           out_ready,
   output decode_t                        out_dec,
   output logic [$clog2(QUEUE_DEPTH):0]   count
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      q_instr [QUEUE_DEPTH];
   logic [31:0]      q_pc    [QUEUE_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             q_empty, accept, move, bypass, pop, push, load;
   logic [31:0]      dec_instr, dec_pc;
   decode_t          dec_next;

   assign in_ready = (count < CNT_W'(QUEUE_DEPTH));
   assign q_empty  = (count == '0);
   assign accept   = in_valid & in_ready & ~flush;
   assign move     = ~out_valid | out_ready;
   assign bypass   = move & q_empty & accept;
   assign pop      = move & ~q_empty;
   assign push     = accept & ~bypass;
   assign load     = pop | bypass;

   // The single decoder sees the queue head, or the live input when the queue is empty.
   assign dec_instr = q_empty ? in_instr : q_instr[rd_ptr];
   assign dec_pc    = q_empty ? in_pc    : q_pc[rd_ptr];

   id_decode_logic #(
      .RF_ADDR_W (RF_ADDR_W),
      .EN_MEXT   (EN_MEXT)
   ) u_decode (
      .instr (dec_instr),
      .pc    (dec_pc),
      .dec   (dec_next)
   );

   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr] <= in_instr;
         q_pc[wr_ptr]    <= in_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         out_dec   <= '0;
      end else if (flush) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (move)
            out_valid <= load;
         if (load)
            out_dec <= dec_next;
      end
   end

endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: default, M-extension and RV32E instances share one stimulus stream.
module tb_id_decode_queue;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_ready, out_valid, in_ready_m, out_valid_m, in_ready_e, out_valid_e;
   decode_t     out_dec, out_dec_m, out_dec_e;
   logic [2:0]  count, count_m, count_e;

   int checks = 0;
   int passed = 0;
   logic [31:0] sb_pc [$];
   logic [4:0]  sb_rd [$];

   always #5 clk = ~clk;

   id_decode_queue dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_dec(out_dec), .count(count));

   id_decode_queue #(.EN_MEXT(1)) dut_m (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_m), .out_ready(out_ready),
      .out_dec(out_dec_m), .count(count_m));

   id_decode_queue #(.RF_ADDR_W(4)) dut_e (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_e),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_e), .out_ready(out_ready),
      .out_dec(out_dec_e), .count(count_e));

   function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      repeat (3) tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
      checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
      checks++; if (out_dec !== decode_t'('0)) $display("FAIL reset_out_dec got %h want 0", out_dec); else passed++;
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
   endtask

   task automatic test_bypass();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0020_81B3; in_pc = 32'h100;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) $display("FAIL bypass_valid got %0b want 1", out_valid); else passed++;
      checks++; if (out_dec.rd !== 5'd3) $display("FAIL bypass_rd got %0d want 3", out_dec.rd); else passed++;
      checks++; if (out_dec.rs1 !== 5'd1) $display("FAIL bypass_rs1 got %0d want 1", out_dec.rs1); else passed++;
      checks++; if (out_dec.rs2 !== 5'd2) $display("FAIL bypass_rs2 got %0d want 2", out_dec.rs2); else passed++;
      checks++; if (out_dec.alu_opcode !== 4'b0000) $display("FAIL bypass_alu got %b want 0000", out_dec.alu_opcode); else passed++;
      checks++; if (out_dec.reg_write !== 1'b1) $display("FAIL bypass_reg_write got %0b want 1", out_dec.reg_write); else passed++;
      checks++; if (out_dec.pc !== 32'h100) $display("FAIL bypass_pc got %h want 100", out_dec.pc); else passed++;
      checks++; if (count !== 3'd0) $display("FAIL bypass_count got %0d want 0", count); else passed++;
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL bypass_consumed got %0b want 0", out_valid); else passed++;
   endtask

   task automatic test_immediates();
      logic [31:0] t_instr [6];
      logic [31:0] t_imm   [6];
      t_instr = '{32'hFE00_0EE3, 32'h1234_52B7, 32'hFE20_AE23, 32'h0080_00EF, 32'h3002_D073, 32'hFFFF_F397};
      t_imm   = '{32'hFFFF_FFFC, 32'h1234_5000, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0005, 32'hFFFF_F000};
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; in_instr = t_instr[k]; in_pc = 32'h300 + 32'(k * 4);
         tick();
         in_valid = 1'b0;
         checks++; if (out_dec.imm !== t_imm[k]) $display("FAIL imm_%0d got %h want %h", k, out_dec.imm, t_imm[k]); else passed++;
         if (k == 0) begin
            checks++; if (out_dec.branch !== 1'b1) $display("FAIL beq_branch got %0b want 1", out_dec.branch); else passed++;
         end
         if (k == 1) begin
            checks++; if (out_dec.rd !== 5'd5) $display("FAIL lui_rd got %0d want 5", out_dec.rd); else passed++;
         end
         if (k == 2) begin
            checks++; if (out_dec.mem_write !== 1'b1) $display("FAIL sw_mem_write got %0b want 1", out_dec.mem_write); else passed++;
         end
         if (k == 4) begin
            checks++; if (out_dec.csr_op !== 2'b01) $display("FAIL csrrwi_op got %b want 01", out_dec.csr_op); else passed++;
         end
         tick();
      end
   endtask

   task automatic test_mext();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0220_81B3; in_pc = 32'h400;
      tick();
      in_instr = 32'h0220_C1B3;
      checks++; if (out_dec.ill_instr !== 1'b1) $display("FAIL mul_noext_ill got %0b want 1", out_dec.ill_instr); else passed++;
      checks++; if (out_dec.reg_write !== 1'b0) $display("FAIL mul_noext_wr got %0b want 0", out_dec.reg_write); else passed++;
      checks++; if (out_valid !== 1'b1) $display("FAIL mul_noext_delivered got %0b want 1", out_valid); else passed++;
      checks++; if (out_dec_m.muldiv !== 1'b1) $display("FAIL mul_ext_muldiv got %0b want 1", out_dec_m.muldiv); else passed++;
      checks++; if (out_dec_m.muldiv_op !== 3'b000) $display("FAIL mul_ext_op got %b want 000", out_dec_m.muldiv_op); else passed++;
      checks++; if (out_dec_m.reg_write !== 1'b1) $display("FAIL mul_ext_wr got %0b want 1", out_dec_m.reg_write); else passed++;
      checks++; if (out_dec_m.ill_instr !== 1'b0) $display("FAIL mul_ext_ill got %0b want 0", out_dec_m.ill_instr); else passed++;
      tick();
      in_valid = 1'b0;
      checks++; if (out_dec_m.muldiv_op !== 3'b100) $display("FAIL div_ext_op got %b want 100", out_dec_m.muldiv_op); else passed++;
      tick();
   endtask

   task automatic test_rv32e();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h01F0_0093; in_pc = 32'h500;
      tick();
      in_instr = 32'h0000_0F93;
      checks++; if (out_dec_e.ill_instr !== 1'b0) $display("FAIL e_addi_ill got %0b want 0", out_dec_e.ill_instr); else passed++;
      checks++; if (out_dec_e.imm !== 32'd31) $display("FAIL e_addi_imm got %h want 1f", out_dec_e.imm); else passed++;
      tick();
      in_valid = 1'b0;
      checks++; if (out_dec_e.ill_instr !== 1'b1) $display("FAIL e_x31_ill got %0b want 1", out_dec_e.ill_instr); else passed++;
      checks++; if (out_dec_e.reg_write !== 1'b0) $display("FAIL e_x31_wr got %0b want 0", out_dec_e.reg_write); else passed++;
      checks++; if (out_dec.ill_instr !== 1'b0) $display("FAIL i_x31_ill got %0b want 0", out_dec.ill_instr); else passed++;
      tick();
   endtask

   task automatic test_back_pressure();
      logic [31:0] epc;
      logic [4:0]  erd;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_instr = r_add(5'(k + 1), 5'd1, 5'd2); in_pc = 32'h200 + 32'(k * 4);
         @(negedge clk);
         checks++; if (in_ready !== 1'b1) $display("FAIL bp_accept_%0d got %0b want 1", k, in_ready); else passed++;
         sb_pc.push_back(in_pc); sb_rd.push_back(5'(k + 1));
         tick();
      end
      in_valid = 1'b0;
      checks++; if (count !== 3'd4) $display("FAIL bp_count got %0d want 4", count); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %0b want 0", in_ready); else passed++;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got %0b want 1", out_valid); else passed++;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && sb_pc.size() != 0; c++) begin
         @(negedge clk);
         if (out_valid) begin
            epc = sb_pc.pop_front(); erd = sb_rd.pop_front();
            checks++; if (out_dec.pc !== epc) $display("FAIL bp_order_pc got %h want %h", out_dec.pc, epc); else passed++;
            checks++; if (out_dec.rd !== erd) $display("FAIL bp_order_rd got %0d want %0d", out_dec.rd, erd); else passed++;
         end
         tick();
      end
      checks++; if (sb_pc.size() != 0) $display("FAIL bp_drain_timeout left %0d want 0", sb_pc.size()); else passed++;
      sb_pc.delete(); sb_rd.delete();
   endtask

   task automatic test_back_to_back();
      int          tag = 0;
      logic [4:0]  rd_v;
      logic [31:0] epc;
      logic [4:0]  erd;
      for (int cyc = 0; cyc < 120; cyc++) begin
         rd_v      = 5'($urandom_range(31, 1));
         in_valid  = ($urandom_range(3, 0) != 0);
         out_ready = ($urandom_range(2, 0) != 0);
         in_instr  = r_add(rd_v, 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
         in_pc     = 32'h1000 + 32'(tag * 4);
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (sb_pc.size() == 0) begin
               checks++; $display("FAIL b2b_unexpected pc got %h want none", out_dec.pc);
            end else begin
               epc = sb_pc.pop_front(); erd = sb_rd.pop_front();
               checks++; if (out_dec.pc !== epc) $display("FAIL b2b_pc got %h want %h", out_dec.pc, epc); else passed++;
               checks++; if (out_dec.rd !== erd) $display("FAIL b2b_rd got %0d want %0d", out_dec.rd, erd); else passed++;
            end
         end
         if (in_valid && in_ready) begin
            sb_pc.push_back(in_pc); sb_rd.push_back(rd_v); tag++;
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 20 && sb_pc.size() != 0; c++) begin
         @(negedge clk);
         if (out_valid) begin
            epc = sb_pc.pop_front(); erd = sb_rd.pop_front();
            checks++; if (out_dec.pc !== epc) $display("FAIL b2b_drain_pc got %h want %h", out_dec.pc, epc); else passed++;
            checks++; if (out_dec.rd !== erd) $display("FAIL b2b_drain_rd got %0d want %0d", out_dec.rd, erd); else passed++;
         end
         tick();
      end
      checks++; if (sb_pc.size() != 0) $display("FAIL b2b_drain_timeout left %0d want 0", sb_pc.size()); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL b2b_final_valid got %0b want 0", out_valid); else passed++;
      sb_pc.delete(); sb_rd.delete();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_instr = r_add(5'(k + 4), 5'd1, 5'd1); in_pc = 32'h600 + 32'(k * 4);
         tick();
      end
      checks++; if (count !== 3'd3) $display("FAIL flush_pre_count got %0d want 3", count); else passed++;
      checks++; if (out_valid !== 1'b1) $display("FAIL flush_pre_valid got %0b want 1", out_valid); else passed++;
      flush = 1'b1; in_instr = r_add(5'd20, 5'd1, 5'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (count !== 3'd0) $display("FAIL flush_count got %0d want 0", count); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid); else passed++;
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_dropped got %0b want 0", out_valid); else passed++;
      out_ready = 1'b1; in_valid = 1'b1; in_instr = r_add(5'd9, 5'd2, 5'd3); in_pc = 32'h700;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_dec.rd !== 5'd9) $display("FAIL flush_recover got v=%0b rd=%0d want v=1 rd=9", out_valid, out_dec.rd); else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_instr = r_add(5'(k + 10), 5'd1, 5'd1); in_pc = 32'h800 + 32'(k * 4);
         tick();
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %0b want 0", out_valid); else passed++;
      checks++; if (count !== 3'd0) $display("FAIL rstmid_count got %0d want 0", count); else passed++;
      checks++; if (out_dec !== decode_t'('0)) $display("FAIL rstmid_dec got %h want 0", out_dec); else passed++;
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_no_emit got %0b want 0", out_valid); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %0b want 1", in_ready); else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_bypass();
      test_immediates();
      test_mext();
      test_rv32e();
      test_back_pressure();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
